// File: rtl/tetris_pkg.sv
// Shared board constants, cell/state types and the optional line-score table
// (score table present only when LINE_CLEAR_SCORE_EN is defined).
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int ID_W    = 3;
    localparam int ADDR_W  = $clog2(BOARD_W * BOARD_H);
    localparam int CNT_W   = $clog2(BOARD_H + 1);
    localparam int X_W     = $clog2(BOARD_W);
    localparam int Y_W     = $clog2(BOARD_H);

    typedef logic [ID_W-1:0] cell_id_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN_RD,
        S_SCAN_CHK,
        S_SHIFT_RD,
        S_SHIFT_WR,
        S_CLR,
        S_DONE
    } lc_state_t;

`ifdef LINE_CLEAR_SCORE_EN
    localparam logic [11:0] SCORE_LUT [0:4] = '{12'd0, 12'd100, 12'd300, 12'd500, 12'd800};

    function automatic logic [11:0] score_of(input logic [CNT_W-1:0] n);
        if (n >= CNT_W'(4))
            return SCORE_LUT[4];
        return SCORE_LUT[int'(n)];
    endfunction
`endif

endpackage

// File: rtl/line_clear_ctr.sv
// Control FSM for the line-clear pass: sequences scan, shift and clear phases
// and issues register-update commands to the datapath in line_clear.
module line_clear_ctr
    import tetris_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic x_eq_last,
    input  logic y_eq_zero,
    input  logic sy_eq_zero,
    input  logic rd_eq_zero,
    output logic init_regs,
    output logic clr_x,
    output logic incr_x,
    output logic decr_y,
    output logic load_sy,
    output logic decr_sy,
    output logic incr_cnt,
    output logic latch_result,
    output logic rd_en,
    output logic rd_shift,
    output logic wr_en,
    output logic wr_clr,
    output logic ready,
    output logic done
);

    lc_state_t state_reg, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        init_regs    = 1'b0;
        clr_x        = 1'b0;
        incr_x       = 1'b0;
        decr_y       = 1'b0;
        load_sy      = 1'b0;
        decr_sy      = 1'b0;
        incr_cnt     = 1'b0;
        latch_result = 1'b0;
        rd_en        = 1'b0;
        rd_shift     = 1'b0;
        wr_en        = 1'b0;
        wr_clr       = 1'b0;
        ready        = 1'b0;
        done         = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    init_regs  = 1'b1;
                    state_next = S_SCAN_RD;
                end
            end
            S_SCAN_RD: begin
                rd_en      = 1'b1;
                state_next = S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                if (rd_eq_zero) begin
                    if (y_eq_zero) begin
                        state_next = S_DONE;
                    end else begin
                        decr_y     = 1'b1;
                        clr_x      = 1'b1;
                        state_next = S_SCAN_RD;
                    end
                end else if (x_eq_last) begin
                    // x wraps to 0 through incr_x, ready for the shift sweep
                    incr_cnt   = 1'b1;
                    load_sy    = 1'b1;
                    incr_x     = 1'b1;
                    state_next = S_SHIFT_RD;
                end else begin
                    incr_x     = 1'b1;
                    state_next = S_SCAN_RD;
                end
            end
            S_SHIFT_RD: begin
                if (sy_eq_zero) begin
                    state_next = S_CLR;
                end else begin
                    rd_en      = 1'b1;
                    rd_shift   = 1'b1;
                    state_next = S_SHIFT_WR;
                end
            end
            S_SHIFT_WR: begin
                wr_en      = 1'b1;
                incr_x     = 1'b1;
                decr_sy    = x_eq_last;
                state_next = S_SHIFT_RD;
            end
            S_CLR: begin
                wr_en  = 1'b1;
                wr_clr = 1'b1;
                incr_x = 1'b1;
                // y is left alone so the row that dropped into it is rescanned
                if (x_eq_last)
                    state_next = S_SCAN_RD;
            end
            S_DONE: begin
                done         = 1'b1;
                latch_result = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: rtl/line_clear.sv
// Removes full board rows bottom-up, shifting the rows above down by one.
// Define LINE_CLEAR_SCORE_EN to add the registered score_delta output.
module line_clear
    import tetris_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    output logic              done,
    output logic [CNT_W-1:0]  lines_cleared,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  cell_id_t          rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output cell_id_t          wr_data
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [11:0]       score_delta
`endif
);

    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [Y_W-1:0]   sy_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] lines_reg;

    logic init_regs, clr_x, incr_x, decr_y, load_sy, decr_sy, incr_cnt, latch_result;
    logic rd_shift, wr_clr;
    logic x_eq_last, y_eq_zero, sy_eq_zero, rd_eq_zero;

    assign x_eq_last  = (x_reg == X_W'(BOARD_W - 1));
    assign y_eq_zero  = (y_reg == '0);
    assign sy_eq_zero = (sy_reg == '0);
    assign rd_eq_zero = (rd_data == '0);

    line_clear_ctr u_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .x_eq_last    (x_eq_last),
        .y_eq_zero    (y_eq_zero),
        .sy_eq_zero   (sy_eq_zero),
        .rd_eq_zero   (rd_eq_zero),
        .init_regs    (init_regs),
        .clr_x        (clr_x),
        .incr_x       (incr_x),
        .decr_y       (decr_y),
        .load_sy      (load_sy),
        .decr_sy      (decr_sy),
        .incr_cnt     (incr_cnt),
        .latch_result (latch_result),
        .rd_en        (rd_en),
        .rd_shift     (rd_shift),
        .wr_en        (wr_en),
        .wr_clr       (wr_clr),
        .ready        (ready),
        .done         (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            sy_reg    <= '0;
            count_reg <= '0;
            lines_reg <= '0;
        end else begin
            if (init_regs || clr_x)
                x_reg <= '0;
            else if (incr_x)
                x_reg <= x_eq_last ? '0 : x_reg + 1'b1;
            if (init_regs)
                y_reg <= Y_W'(BOARD_H - 1);
            else if (decr_y)
                y_reg <= y_reg - 1'b1;
            if (load_sy)
                sy_reg <= y_reg;
            else if (decr_sy)
                sy_reg <= sy_reg - 1'b1;
            if (init_regs)
                count_reg <= '0;
            else if (incr_cnt && count_reg != CNT_W'(BOARD_H))
                count_reg <= count_reg + 1'b1;
            if (latch_result)
                lines_reg <= count_reg;
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [11:0] score_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            score_reg <= '0;
        else if (latch_result)
            score_reg <= score_of(count_reg);
    end

    assign score_delta = score_reg;
`endif

    logic [Y_W-1:0] rd_row;
    logic [Y_W-1:0] wr_row;

    // Shift reads come from the row above the destination row sy
    assign rd_row  = rd_shift ? sy_reg - 1'b1 : y_reg;
    assign wr_row  = wr_clr ? '0 : sy_reg;
    assign rd_addr = ADDR_W'(rd_row) * ADDR_W'(BOARD_W) + ADDR_W'(x_reg);
    assign wr_addr = ADDR_W'(wr_row) * ADDR_W'(BOARD_W) + ADDR_W'(x_reg);
    assign wr_data = wr_clr ? '0 : rd_data;

    assign lines_cleared = lines_reg;

endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
- Downstream of the collision/placement controller; runs once per locked piece.
- After the piece cells are written into board RAM, the top-level control pulses Start.
- The block scans the board bottom-up for full rows and removes each one by shifting all rows above it down one row, writing zeros into row 0.
- It reports the number of rows cleared to the score/spawn logic, then returns to idle.

Parameters:
- BOARD_W, 10, board columns (x).
- BOARD_H, 20, board rows (y); row 0 is the top.
- ID_W, 3, cell id width; id 0 means an empty cell.
- ADDR_W, $clog2(BOARD_W*BOARD_H), board RAM address width.
- CNT_W, $clog2(BOARD_H+1), lines_cleared width.

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request a clear pass; sampled only in idle.
- Ready  out  1  high in idle.
- Done  out  1  one-cycle pulse when the pass completes.
- lines_cleared  out  CNT_W  rows removed in the last pass; held until the next Start is accepted.
- rd_en  out  1  board RAM read strobe.
- rd_addr  out  ADDR_W  read address, y*BOARD_W+x.
- rd_data  in  ID_W  read data, valid the cycle after rd_en (synchronous RAM).
- wr_en  out  1  board RAM write strobe.
- wr_addr  out  ADDR_W  write address, y*BOARD_W+x.
- wr_data  out  ID_W  write data.

Behaviour:
- Reset low, asynchronous: state S_idle, x=0, y=0, sy=0, count=0. Outputs: Ready=1, Done=0, lines_cleared=0, rd_en=0, wr_en=0.
- Reset mid-pass aborts immediately with no further writes. Board contents may be partially shifted; recovery is the caller's problem.
- Outputs are Moore, decoded from the state. Addresses are combinational from the x/y/sy registers.
- States and transitions:
  - S_idle: Ready=1. On Start: y<=BOARD_H-1, x<=0, count<=0; go to S_scan_rd. Otherwise stay.
  - S_scan_rd: rd_en=1, rd_addr={y,x}; go to S_scan_chk.
  - S_scan_chk: rd_data is valid here.
    - rd_data==0 (row not full): if y==0 go to S_done; else y<=y-1, x<=0, go to S_scan_rd.
    - rd_data!=0 and x==BOARD_W-1 (row full): count<=count+1, sy<=y, x<=0; go to S_shift_rd.
    - Otherwise: x<=x+1; go to S_scan_rd.
  - S_shift_rd:
    - If sy==0, go to S_clr.
    - Else rd_en=1, rd_addr={sy-1,x}; go to S_shift_wr.
  - S_shift_wr: wr_en=1, wr_addr={sy,x}, wr_data=rd_data.
    - If x==BOARD_W-1: x<=0, sy<=sy-1.
    - Else x<=x+1.
    - Go to S_shift_rd.
  - S_clr: wr_en=1, wr_addr={0,x}, wr_data=0.
    - If x==BOARD_W-1: x<=0; go to S_scan_rd with y unchanged, so the row shifted into y is rescanned.
    - Else x<=x+1.
  - S_done: Done=1, lines_cleared<=count; go to S_idle.
- Boundaries:
  - Full row at y=0 goes straight to S_clr.
  - Consecutive full rows are each caught by the rescan.
  - Start while not idle is ignored.
  - rd_en and wr_en are never high in the same cycle.
  - count saturates at BOARD_H.
- Timing:
  - Empty-board pass is 2*BOARD_H cycles, then Done.
  - Each clear adds 2*BOARD_W*y + BOARD_W cycles.

Optional Feature:
- LINE_CLEAR_SCORE_EN defined: adds output score_delta [11:0], registered at S_done alongside lines_cleared.
  - Values: 0→0, 1→100, 2→300, 3→500, 4 or more→800.
  - Reset value 0.
- Undefined: port and table absent; behaviour otherwise identical.

Decomposition:
- Shared package tetris_pkg:
  - BOARD_W, BOARD_H, ID_W.
  - cell_id_t.
  - the line_clear state enum.
  - the score lookup constant array (under the macro).
- Natural sub-module: line_clear_ctr, the FSM only. It takes x_eQ_last, y_eQ_zero, sy_eQ_zero and rd_eQ_zero, and drives init_regs, incr_x, decr_y, load_sy, decr_sy, incr_cnt and the strobes.
- Counters, address math and output registers stay in line_clear.

Test Plan:
- Empty board, Start for 1 cycle → Done exactly 41 cycles after the Start sample, lines_cleared=0, no wr_en ever.
- Row 19 full (ids 1..7), row 18 only x=3 id=5 → lines_cleared=1; afterwards row 19 = only x=3 id 5, row 18 and row 0 all zero.
- Rows 16–19 full, row 15 x=0 id=2 → lines_cleared=4, row 19 x=0 id=2, rows 0–18 otherwise zero; score_delta=800 with LINE_CLEAR_SCORE_EN.
- Rows 17 and 19 full, row 18 with x=9 empty → lines_cleared=2, row 19 = old row 18, rows 0–18 zero.
- Only row 0 full → S_clr writes 10 zeros to addresses 0..9, lines_cleared=1, no shift reads issued.
- Reset driven low during S_shift_wr → wr_en=0 the same cycle (asynchronous), Ready=1; Start held high throughout a pass → exactly one Done per pass, the next pass begins after S_idle.
